// File: rtl/mio_pkg.sv
// Shared definitions for the CPU memory/IO responder: region codes,
// FSM state encoding and parameter defaults.
package mio_pkg;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_SEG  = 4'hE;
  localparam logic [3:0] REG_GPIO = 4'hF;

  localparam int unsigned RAM_AW_DEF  = 10;
  localparam int unsigned RAM_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } mio_state_t;

endpackage

// File: rtl/mio_addr_decode.sv
// Region decode of the top address nibble into RAM / SEG / GPIO / unmapped.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [3:0] region,
  output logic       is_ram,
  output logic       is_seg,
  output logic       is_gpio,
  output logic       unmapped
);

  // One-hot region flags; anything not recognised is unmapped.
  always_comb begin
    is_ram   = (region == REG_RAM);
    is_seg   = (region == REG_SEG);
    is_gpio  = (region == REG_GPIO);
    unmapped = !(is_ram || is_seg || is_gpio);
  end

endmodule

// File: rtl/mio_bus_responder.sv
// Responder side of the CPU memory/IO handshake. Decodes each request into
// RAM, seven-segment, GPIO or unmapped space, inserts RAM read wait states and
// returns a one-cycle MIO_ready with the load data.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW  = RAM_AW_DEF,
  parameter int unsigned RAM_LAT = RAM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Data_write,
  output logic [31:0]       Data_read,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  input  logic [3:0]        btn_in,
  output logic [15:0]       led_out,
  output logic [31:0]       seg_out
);

  localparam int unsigned CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RAM_LAT - 1);

  mio_state_t  state;
  logic [CW-1:0] wait_cnt;
  logic        is_ram, is_seg, is_gpio, unmapped;
  logic [31:0] periph_rd;
  logic        unused_addr_bits;

  // Byte-lane bits and address bits above the RAM window play no part.
  assign unused_addr_bits = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0], unmapped};

  mio_addr_decode u_decode (
    .region   (addr_bus[31:28]),
    .is_ram   (is_ram),
    .is_seg   (is_seg),
    .is_gpio  (is_gpio),
    .unmapped (unmapped)
  );

  // Read data for non-RAM regions; unmapped space reads as zero.
  always_comb begin
    periph_rd = '0;
    if (is_seg)
      periph_rd = {16'h0000, sw_in};
    else if (is_gpio)
      periph_rd = {12'h000, btn_in, sw_in};
  end

  // Request FSM with registered handshake, RAM strobes and peripheral registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      MIO_ready <= 1'b0;
      ram_we    <= 1'b0;
      Data_read <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      led_out   <= '0;
      seg_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CPU_MIO) begin
            ram_addr <= addr_bus[RAM_AW+1:2];
            ram_din  <= Data_write;
            if (is_ram && !mem_w) begin
              state    <= ST_RD_WAIT;
              wait_cnt <= CNT_INIT;
            end else begin
              // Everything except a RAM load completes in one cycle; the
              // write strobe is raised together with ready so it lasts
              // exactly the ACK cycle.
              state     <= ST_ACK;
              MIO_ready <= 1'b1;
              ram_we    <= is_ram && mem_w;
              if (!mem_w)
                Data_read <= periph_rd;
              if (mem_w && is_seg)
                seg_out <= Data_write;
              if (mem_w && is_gpio)
                led_out <= Data_write[15:0];
            end
          end
        end
        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            Data_read <= ram_dout;
            MIO_ready <= 1'b1;
            state     <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ACK: begin
          MIO_ready <= 1'b0;
          ram_we    <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          MIO_ready <= 1'b0;
          ram_we    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: the driver pushes the expected
// response of each request, a negedge monitor pops and compares on MIO_ready.
module tb_mio_bus_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CPU_MIO = 1'b0;
  logic          mem_w = 1'b0;
  logic [31:0]   addr_bus = '0;
  logic [31:0]   Data_write = '0;
  logic [31:0]   Data_read;
  logic          MIO_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;
  logic [15:0]   sw_in = '0;
  logic [3:0]    btn_in = '0;
  logic [15:0]   led_out;
  logic [31:0]   seg_out;

  mio_bus_responder #(.RAM_AW(AW), .RAM_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CPU_MIO    (CPU_MIO),
    .mem_w      (mem_w),
    .addr_bus   (addr_bus),
    .Data_write (Data_write),
    .Data_read  (Data_read),
    .MIO_ready  (MIO_ready),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .sw_in      (sw_in),
    .btn_in     (btn_in),
    .led_out    (led_out),
    .seg_out    (seg_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM device: data appears LAT cycles after the address is registered.
  logic [31:0] tb_mem [0:(1<<AW)-1];
  logic [31:0] rd_s1, rd_s2;
  always @(posedge clk) begin
    if (ram_we) tb_mem[ram_addr] <= ram_din;
    rd_s1 <= tb_mem[ram_addr];
    rd_s2 <= rd_s1;
  end
  assign ram_dout = rd_s2;

  typedef struct {
    int unsigned id;
    int unsigned issue;
    int unsigned lat;
    logic        chk_data;
    logic [31:0] data;
    logic        exp_we;
    logic [AW-1:0] exp_addr;
    logic [31:0] exp_din;
    logic [15:0] exp_led;
    logic [31:0] exp_seg;
  } item_t;

  item_t sb[$];
  item_t mon_it;

  // Reference state
  logic [31:0] ref_mem [int];
  logic [15:0] ref_led = '0;
  logic [31:0] ref_seg = '0;
  int unsigned req_id = 0;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: every ready must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (MIO_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready: got MIO_ready=1 at cycle %0d expected no pending request", cyc);
        end else begin
          mon_it = sb.pop_front();
          chk($sformatf("req%0d latency", mon_it.id), cyc - mon_it.issue, mon_it.lat);
          if (mon_it.chk_data)
            chk($sformatf("req%0d Data_read", mon_it.id), Data_read, mon_it.data);
          chk($sformatf("req%0d ram_we", mon_it.id), 32'(ram_we), 32'(mon_it.exp_we));
          if (mon_it.exp_we) begin
            chk($sformatf("req%0d ram_addr", mon_it.id), 32'(ram_addr), 32'(mon_it.exp_addr));
            chk($sformatf("req%0d ram_din", mon_it.id), ram_din, mon_it.exp_din);
          end
          chk($sformatf("req%0d led_out", mon_it.id), 32'(led_out), 32'(mon_it.exp_led));
          chk($sformatf("req%0d seg_out", mon_it.id), seg_out, mon_it.exp_seg);
        end
      end else if (ram_we) begin
        checks++;
        errors++;
        $display("FAIL stray_we: got ram_we=1 without MIO_ready at cycle %0d expected 0", cyc);
      end
    end
  end

  // Issue one request at a negedge; b2b means the previous ACK is still on.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic b2b);
    item_t it;
    logic [3:0] rg;
    logic [AW-1:0] idx;
    int unsigned n;
    rg  = a[31:28];
    idx = a[AW+1:2];
    CPU_MIO    = 1'b1;
    mem_w      = w;
    addr_bus   = a;
    Data_write = d;
    req_id++;
    it.id       = req_id;
    it.issue    = cyc + (b2b ? 1 : 0);
    it.lat      = 1;
    it.chk_data = !w;
    it.data     = '0;
    it.exp_we   = 1'b0;
    it.exp_addr = idx;
    it.exp_din  = d;
    if (rg == 4'h0) begin
      if (w) begin
        ref_mem[int'(idx)] = d;
        it.exp_we = 1'b1;
      end else begin
        it.data = ref_mem[int'(idx)];
        it.lat  = LAT + 1;
      end
    end else if (rg == 4'hE) begin
      if (w) ref_seg = d;
      else   it.data = {16'h0000, sw_in};
    end else if (rg == 4'hF) begin
      if (w) ref_led = d[15:0];
      else   it.data = {12'h000, btn_in, sw_in};
    end
    it.exp_led = ref_led;
    it.exp_seg = ref_seg;
    sb.push_back(it);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!MIO_ready && n < 40);
    if (!MIO_ready) begin
      checks++;
      errors++;
      $display("FAIL req%0d timeout: got no MIO_ready in %0d cycles expected within %0d", req_id, n, LAT + 1);
      sb.delete();
    end
  endtask

  task automatic go_idle(input int unsigned gap);
    CPU_MIO = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic w;
    logic [31:0] a, d;
    logic [AW-1:0] idx;
    int unsigned r;
    logic b2b;

    // Reset held 3 cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst MIO_ready", 32'(MIO_ready), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst Data_read", Data_read, 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst ram_din", ram_din, 32'd0);
    chk("rst led_out", 32'(led_out), 32'd0);
    chk("rst seg_out", seg_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    go_idle(1);
    do_req(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    go_idle(1);
    do_req(1'b1, 32'hF000_0000, 32'h0001_A5A5, 1'b0);
    go_idle(1);
    sw_in = 16'h1234; btn_in = 4'h5;
    do_req(1'b0, 32'hF000_0000, 32'h0, 1'b0);
    go_idle(1);
    do_req(1'b1, 32'hE000_0004, 32'h1357_9BDF, 1'b0);
    go_idle(1);
    do_req(1'b0, 32'hE000_0004, 32'h0, 1'b0);
    go_idle(1);
    do_req(1'b0, 32'h8000_0000, 32'h0, 1'b0);
    go_idle(1);
    do_req(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 1'b0);
    go_idle(2);
    do_req(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    go_idle(1);

    // CPU_MIO held across 4 GPIO stores
    do_req(1'b1, 32'hF000_0000, 32'h0000_0001, 1'b0);
    do_req(1'b1, 32'hF000_0000, 32'h0000_0002, 1'b1);
    do_req(1'b1, 32'hF000_0000, 32'h0000_0003, 1'b1);
    do_req(1'b1, 32'hF000_0000, 32'h0000_0004, 1'b1);
    go_idle(5);
    chk("idle hold led_out", 32'(led_out), 32'(ref_led));
    chk("idle hold MIO_ready", 32'(MIO_ready), 32'd0);

    // Reset during a RAM read wait
    CPU_MIO = 1'b1; mem_w = 1'b0; addr_bus = 32'h0000_0010;
    @(negedge clk);
    rst_n = 1'b0;
    CPU_MIO = 1'b0;
    sb.delete();
    ref_led = '0;
    ref_seg = '0;
    repeat (3) begin
      @(negedge clk);
      chk("abort MIO_ready", 32'(MIO_ready), 32'd0);
      chk("abort ram_we", 32'(ram_we), 32'd0);
    end
    chk("abort Data_read", Data_read, 32'd0);
    chk("abort led_out", 32'(led_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h0000_0010, 32'h0, 1'b0);

    // Randomised traffic
    b2b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 3);
      w = 1'($urandom);
      d = $urandom;
      a = $urandom;
      case (r)
        0: a[31:28] = 4'h0;
        1: a[31:28] = 4'hE;
        2: a[31:28] = 4'hF;
        default: a[31:28] = 4'($urandom_range(1, 13));
      endcase
      idx = a[AW+1:2];
      if (r == 0 && !w && !ref_mem.exists(int'(idx))) w = 1'b1;
      if (!b2b) go_idle($urandom_range(1, 2));
      sw_in  = 16'($urandom);
      btn_in = 4'($urandom);
      do_req(w, a, d, b2b);
      b2b = 1'($urandom);
    end
    go_idle(8);
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
